// File: rtl/ssd_scan_if.sv
// ssd_scan_if: time/edit inputs and scanned digit outputs of the seven-segment scan controller.
// Latency: n/a (signal bundle only).
// Backpressure: none; the display side never stalls the time source.
interface ssd_scan_if #(
    parameter int DIGITS = 4
) ();
    logic [4:0]        hour;
    logic [7:0]        min_bcd;
    logic [7:0]        sec_bcd;
    logic              mode_12h;
    logic              view_sec;
    logic [DIGITS-1:0] edit_mask;
    logic [DIGITS-1:0] ssd_ctl;
    logic [3:0]        ssd_in;
    logic              pm;

    modport master (
        output hour, min_bcd, sec_bcd, mode_12h, view_sec, edit_mask,
        input  ssd_ctl, ssd_in, pm
    );

    modport slave (
        input  hour, min_bcd, sec_bcd, mode_12h, view_sec, edit_mask,
        output ssd_ctl, ssd_in, pm
    );
endinterface

// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: frame-snapshot 4/6-digit scan with 12/24 h hour conversion and edit blink (SSD_GHOST_BLANK_EN adds a blank cycle per slot).
// Latency: all outputs registered; an input change reaches the display within DIGITS*DWELL+1 cycles.
// Backpressure: none; the scan free-runs and inputs are sampled only at frame start.
module ssd_scan_ctrl #(
    parameter int DIGITS     = 4,
    parameter int DWELL      = 50000,
    parameter int BLINK_HALF = 25000000
) (
    input  logic      clk,
    input  logic      rst_n,
    ssd_scan_if.slave bus
);
    localparam int IW = $clog2(DIGITS);
    localparam int CW = $clog2(DWELL);
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    typedef enum logic {ST_IDLE, ST_SCAN} state_t;

    state_t            state, state_n;
    logic [IW-1:0]     idx, idx_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic              load;
    logic [BW-1:0]     blk_cnt;
    logic              blk_on;
    logic [4:0]        s_hour, e_hour, hd;
    logic [7:0]        s_min, s_sec, e_min, e_sec;
    logic              s_12h, s_vsec, e_12h, e_vsec;
    logic [3:0]        h_tens, h_ones;
    logic              pm_n;
    logic [3:0]        page [DIGITS];
    logic [3:0]        code_n, code_q;
    logic [DIGITS-1:0] ctl_n, ctl_q;
    logic              pm_q;
    logic              ghost;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_n;
    end

    // The first cycle out of reset opens slot 0 and takes the initial snapshot.
    always_comb begin
        state_n = ST_SCAN;
        idx_n   = idx;
        cnt_n   = cnt + 1'b1;
        load    = 1'b0;
        if (state == ST_IDLE) begin
            idx_n = '0;
            cnt_n = '0;
            load  = 1'b1;
        end else if (cnt == CW'(DWELL - 1)) begin
            cnt_n = '0;
            if (idx == IW'(DIGITS - 1)) begin
                idx_n = '0;
                load  = 1'b1;
            end else begin
                idx_n = idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= '0;
            cnt    <= '0;
            s_hour <= '0;
            s_min  <= '0;
            s_sec  <= '0;
            s_12h  <= 1'b0;
            s_vsec <= 1'b0;
        end else begin
            idx <= idx_n;
            cnt <= cnt_n;
            if (load) begin
                s_hour <= bus.hour;
                s_min  <= bus.min_bcd;
                s_sec  <= bus.sec_bcd;
                s_12h  <= bus.mode_12h;
                s_vsec <= bus.view_sec;
            end
        end
    end

    // Bypass the snapshot on the load edge so a new frame shows its own values from cycle one.
    assign e_hour = load ? bus.hour     : s_hour;
    assign e_min  = load ? bus.min_bcd  : s_min;
    assign e_sec  = load ? bus.sec_bcd  : s_sec;
    assign e_12h  = load ? bus.mode_12h : s_12h;
    assign e_vsec = load ? bus.view_sec : s_vsec;

    always_comb begin
        hd   = e_hour;
        pm_n = 1'b0;
        if (e_12h) begin
            if (e_hour == 5'd0)       hd = 5'd12;
            else if (e_hour >= 5'd13) hd = e_hour - 5'd12;
            pm_n = (e_hour >= 5'd12) && (e_hour <= 5'd23);
        end
        if (hd >= 5'd20) begin
            h_tens = 4'd2;
            h_ones = 4'(hd - 5'd20);
        end else if (hd >= 5'd10) begin
            h_tens = 4'd1;
            h_ones = 4'(hd - 5'd10);
        end else begin
            h_tens = 4'd0;
            h_ones = 4'(hd);
        end
        if (e_hour > 5'd23) begin
            h_tens = 4'hF;
            h_ones = 4'hF;
            pm_n   = 1'b0;
        end
    end

    if (DIGITS == 6) begin : g_six
        always_comb begin
            page[0] = h_tens;
            page[1] = h_ones;
            page[2] = e_min[7:4];
            page[3] = e_min[3:0];
            page[4] = e_sec[7:4];
            page[5] = e_sec[3:0];
        end
    end else begin : g_four
        always_comb begin
            if (e_vsec) begin
                page[0] = e_sec[7:4];
                page[1] = e_sec[3:0];
                page[2] = e_12h ? (pm_n ? 4'hB : 4'hA) : 4'hF;
                page[3] = e_12h ? 4'hC : 4'hF;
            end else begin
                page[0] = h_tens;
                page[1] = h_ones;
                page[2] = e_min[7:4];
                page[3] = e_min[3:0];
            end
        end
    end

    assign code_n = page[idx_n];

    // Blink restarts visible whenever editing begins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt <= '0;
            blk_on  <= 1'b1;
        end else if (bus.edit_mask == '0) begin
            blk_cnt <= '0;
            blk_on  <= 1'b1;
        end else if (blk_cnt == BW'(BLINK_HALF - 1)) begin
            blk_cnt <= '0;
            blk_on  <= ~blk_on;
        end else begin
            blk_cnt <= blk_cnt + 1'b1;
        end
    end

    always_comb begin
        ctl_n = '1;
        for (int j = 0; j < DIGITS; j++) begin
            if ((j == DIGITS - 1 - int'(idx_n)) && !(bus.edit_mask[j] && !blk_on))
                ctl_n[j] = 1'b0;
        end
    end

`ifdef SSD_GHOST_BLANK_EN
    assign ghost = (cnt_n == '0);
`else
    assign ghost = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl_q  <= '1;
            code_q <= 4'hF;
            pm_q   <= 1'b0;
        end else begin
            ctl_q  <= ghost ? '1 : ctl_n;
            code_q <= ghost ? 4'hF : code_n;
            pm_q   <= pm_n;
        end
    end

    assign bus.ssd_ctl = ctl_q;
    assign bus.ssd_in  = code_q;
    assign bus.pm      = pm_q;
endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Bench for ssd_scan_ctrl: a 4-digit and a 6-digit instance share stimulus; a cycle-position model predicts every output.
module tb_ssd_scan_ctrl;
    localparam int DW = 4;
    localparam int BH = 16;
`ifdef SSD_GHOST_BLANK_EN
    localparam int LC = DW - 1;
`else
    localparam int LC = DW;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] hour;
    logic [7:0] min_bcd, sec_bcd;
    logic       mode_12h, view_sec;
    logic [5:0] edit_mask;

    int errors, checks;
    bit checking;

    ssd_scan_if #(.DIGITS(4)) if4 ();
    ssd_scan_if #(.DIGITS(6)) if6 ();

    assign if4.hour = hour;       assign if6.hour = hour;
    assign if4.min_bcd = min_bcd; assign if6.min_bcd = min_bcd;
    assign if4.sec_bcd = sec_bcd; assign if6.sec_bcd = sec_bcd;
    assign if4.mode_12h = mode_12h; assign if6.mode_12h = mode_12h;
    assign if4.view_sec = view_sec; assign if6.view_sec = view_sec;
    assign if4.edit_mask = edit_mask[3:0];
    assign if6.edit_mask = edit_mask;

    ssd_scan_ctrl #(.DIGITS(4), .DWELL(DW), .BLINK_HALF(BH)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
    ssd_scan_ctrl #(.DIGITS(6), .DWELL(DW), .BLINK_HALF(BH)) dut6 (.clk(clk), .rst_n(rst_n), .bus(if6));

    always #5 clk = ~clk;

    logic [5:0] act_ctl [2];
    logic [3:0] act_code [2];
    logic       act_pm [2];
    assign act_ctl[0] = {2'b11, if4.ssd_ctl};
    assign act_ctl[1] = if6.ssd_ctl;
    assign act_code[0] = if4.ssd_in;
    assign act_code[1] = if6.ssd_in;
    assign act_pm[0] = if4.pm;
    assign act_pm[1] = if6.pm;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: what digit code belongs at display position idx for a given snapshot.
    function automatic logic [3:0] model_code(input int d, input int idx, input logic [4:0] h,
                                              input logic [7:0] m, input logic [7:0] s,
                                              input logic t12, input logic vs);
        int hv, shown;
        logic [3:0] pg [6];
        logic [3:0] ht, ho;
        hv = int'(h);
        if (hv > 23) begin
            ht = 4'hF;
            ho = 4'hF;
        end else begin
            shown = t12 ? ((hv % 12 == 0) ? 12 : hv % 12) : hv;
            ht = 4'(shown / 10);
            ho = 4'(shown % 10);
        end
        pg = '{ht, ho, m[7:4], m[3:0], s[7:4], s[3:0]};
        if (d == 4 && vs) begin
            pg[0] = s[7:4];
            pg[1] = s[3:0];
            pg[2] = t12 ? ((hv >= 12 && hv <= 23) ? 4'hB : 4'hA) : 4'hF;
            pg[3] = t12 ? 4'hC : 4'hF;
        end
        return pg[idx];
    endfunction

    int         mn [2], mrun [2], mp [2];
    logic [4:0] sh [2];
    logic [7:0] sm [2], ss [2];
    logic       s12 [2], svs [2];
    logic [5:0] exp_ctl [2];
    logic [3:0] exp_code [2];
    logic       exp_pm [2];

    // Model: position within the frame follows from the number of edges since reset release.
    initial begin
        int md, midx;
        logic [5:0] mk;
        bit mdark;
        for (int i = 0; i < 2; i++) begin
            mn[i] = 0; mrun[i] = 0; mp[i] = -1;
            exp_ctl[i] = 6'h3F; exp_code[i] = 4'hF; exp_pm[i] = 1'b0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            for (int i = 0; i < 2; i++) begin
                if (!rst_n) begin
                    mn[i] = 0; mrun[i] = 0; mp[i] = -1;
                    exp_ctl[i] = 6'h3F; exp_code[i] = 4'hF; exp_pm[i] = 1'b0;
                end else begin
                    md = (i == 0) ? 4 : 6;
                    mk = (i == 0) ? {2'b00, edit_mask[3:0]} : edit_mask;
                    mn[i] = mn[i] + 1;
                    mp[i] = (mn[i] - 1) % (md * DW);
                    if (mp[i] == 0) begin
                        sh[i] = hour; sm[i] = min_bcd; ss[i] = sec_bcd;
                        s12[i] = mode_12h; svs[i] = view_sec;
                    end
                    midx = mp[i] / DW;
                    if (mk == 6'd0) begin
                        mdark = 1'b0;
                        mrun[i] = 0;
                    end else begin
                        mdark = ((mrun[i] / BH) % 2) == 1;
                        mrun[i] = mrun[i] + 1;
                    end
                    exp_ctl[i] = 6'h3F;
                    exp_ctl[i][md-1-midx] = 1'b0;
                    if (mdark) exp_ctl[i] = exp_ctl[i] | mk;
                    exp_code[i] = model_code(md, midx, sh[i], sm[i], ss[i], s12[i], svs[i]);
                    exp_pm[i] = s12[i] && (int'(sh[i]) >= 12) && (int'(sh[i]) <= 23);
`ifdef SSD_GHOST_BLANK_EN
                    if (mp[i] % DW == 0) begin
                        exp_ctl[i] = 6'h3F;
                        exp_code[i] = 4'hF;
                    end
`endif
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (checking) begin
                for (int i = 0; i < 2; i++) begin
                    chk($sformatf("cyc_ctl%0d", i), 32'(act_ctl[i]), 32'(exp_ctl[i]));
                    chk($sformatf("cyc_code%0d", i), 32'(act_code[i]), 32'(exp_code[i]));
                    chk($sformatf("cyc_pm%0d", i), 32'(act_pm[i]), 32'(exp_pm[i]));
                end
            end
        end
    end

    task automatic wait_frame(input int inst);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        for (int b = 0; b < 200 && !ok; b++) begin
            @(negedge clk);
            if (mp[inst] == 0) ok = 1'b1;
        end
        chk($sformatf("frame_wait%0d", inst), 32'(ok), 32'd1);
    endtask

    // Starts at the first negedge of a frame; samples the last cycle of every slot.
    task automatic check_frame(input int inst, input logic [23:0] codes, input logic epm, input string nm);
        int d;
        d = (inst == 0) ? 4 : 6;
        for (int k = 0; k < d; k++) begin
            if (k > 0) @(negedge clk);
            repeat (DW - 1) @(negedge clk);
            chk($sformatf("%s_d%0d", nm, k), 32'(act_code[inst]), 32'(codes[4*(d-1-k) +: 4]));
        end
        chk({nm, "_pm"}, 32'(act_pm[inst]), 32'(epm));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int n0, n2;
        logic [3:0] e;
        errors = 0; checks = 0; checking = 1'b0;
        rst_n = 1'b0;
        hour = 5'd0; min_bcd = 8'h00; sec_bcd = 8'h00;
        mode_12h = 1'b0; view_sec = 1'b0; edit_mask = 6'd0;
        repeat (3) @(posedge clk);
        #2;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_ctl%0d", i), 32'(act_ctl[i]), 32'h3F);
            chk($sformatf("rst_code%0d", i), 32'(act_code[i]), 32'hF);
            chk($sformatf("rst_pm%0d", i), 32'(act_pm[i]), 32'd0);
        end
        checking = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("hold_ctl", 32'(if4.ssd_ctl), 32'hF);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            e = (c <= 4) ? 4'b0111 : 4'b1011;
`ifdef SSD_GHOST_BLANK_EN
            if (c == 1 || c == 5) e = 4'hF;
`endif
            chk($sformatf("release_c%0d", c), 32'(if4.ssd_ctl), 32'(e));
        end

        mode_12h = 1'b1; hour = 5'd13; min_bcd = 8'h45; sec_bcd = 8'h59;
        wait_frame(0); check_frame(0, 24'h000145, 1'b1, "h13_12h");
        hour = 5'd0;
        wait_frame(0); check_frame(0, 24'h001245, 1'b0, "h0_12h");
        hour = 5'd12;
        wait_frame(0); check_frame(0, 24'h001245, 1'b1, "h12_12h");
        mode_12h = 1'b0; hour = 5'd13;
        wait_frame(0); check_frame(0, 24'h001345, 1'b0, "h13_24h");
        view_sec = 1'b1; sec_bcd = 8'h37; hour = 5'd15; mode_12h = 1'b1;
        wait_frame(0); check_frame(0, 24'h0037BC, 1'b1, "sec_12h");
        mode_12h = 1'b0;
        wait_frame(0); check_frame(0, 24'h0037FF, 1'b0, "sec_24h");

        view_sec = 1'b0; hour = 5'd9;
        wait_frame(0);
        wait_frame(0);
        hour = 5'd10;
        check_frame(0, 24'h000945, 1'b0, "tear_old");
        @(negedge clk);
        check_frame(0, 24'h001045, 1'b0, "tear_new");

        edit_mask = 6'b000011;
        for (int w = 0; w < 3; w++) begin
            n0 = 0; n2 = 0;
            repeat (BH) begin
                @(negedge clk);
                if (act_ctl[0][0] == 1'b0) n0++;
                if (act_ctl[0][2] == 1'b0) n2++;
            end
            chk($sformatf("blink_w%0d_right", w), 32'(n0), 32'((w == 1) ? 0 : LC));
            chk($sformatf("blink_w%0d_steady", w), 32'(n2), 32'(LC));
        end
        repeat (8) @(negedge clk);
        edit_mask = 6'd0;
        n0 = 0;
        repeat (BH) begin
            @(negedge clk);
            if (act_ctl[0][0] == 1'b0) n0++;
        end
        chk("unblink_right", 32'(n0), 32'(LC));

        mode_12h = 1'b0; hour = 5'd9; min_bcd = 8'h05; sec_bcd = 8'h59;
        wait_frame(1); check_frame(1, 24'h090559, 1'b0, "six_h9");
        mode_12h = 1'b1; hour = 5'd24;
        wait_frame(1); check_frame(1, 24'hFF0559, 1'b0, "six_h24");

        for (int it = 0; it < 400; it++) begin
            @(posedge clk);
            #2;
            if ($urandom_range(0, 7) == 0) begin
                hour = 5'($urandom_range(0, 31));
                min_bcd = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
                sec_bcd = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
                mode_12h = 1'($urandom_range(0, 1));
                view_sec = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 31) == 0)
                edit_mask = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(1, 63)) : 6'd0;
            if (it == 211) begin
                rst_n = 1'b0;
                #1;
                chk("midrst_ctl4", 32'(if4.ssd_ctl), 32'hF);
                chk("midrst_code4", 32'(if4.ssd_in), 32'hF);
                chk("midrst_pm6", 32'(if6.pm), 32'd0);
                @(posedge clk);
                #2;
                rst_n = 1'b1;
            end
        end
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
